rr_arbiter4: RTL



---
 rtl/arb_pkg.sv | 35 +++
 rtl/rr_arbiter4_if.sv | 15 +
 rtl/arb_dec2to4.sv | 13 +
 rtl/rr_arbiter4.sv | 118 +++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter.
// Holds the state encoding, the default hold limit and the round-robin search.
package arb_pkg;

    localparam int NREQ         = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Walk from last+1 around to last; iterating from lowest priority upward
    // lets the final hit be the winner without an early exit.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [1:0] last);
        pick_t      p;
        logic [1:0] idx;
        p = '{found: 1'b0, idx: 2'd0};
        for (int k = NREQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between the requesting units and rr_arbiter4.
// master = requester side, slave = arbiter side.
interface rr_arbiter4_if;
    import arb_pkg::*;

    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_valid;
    logic            busy;

    modport master (output req, input gnt, gnt_idx, gnt_valid, busy);
    modport slave  (input req, output gnt, gnt_idx, gnt_valid, busy);

endinterface

// File: rtl/arb_dec2to4.sv
// 2-bit index to 4-bit one-hot decoder; i_en low forces an all-zero output.
module arb_dec2to4 (
    input  logic [1:0] i_idx,
    input  logic       i_en,
    output logic [3:0] o_onehot
);

    always_comb begin
        o_onehot = 4'b0000;
        if (i_en) o_onehot[i_idx] = 1'b1;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// 4-requester round-robin arbiter with registered, held one-hot grant.
// Define ARB_TIMEOUT_EN to preempt an owner after MAX_HOLD cycles when others wait.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic          clk,
    input  logic          rst,
    rr_arbiter4_if.slave  bus
);

    if (MAX_HOLD < 2 || MAX_HOLD > 15 || (2 ** CNT_W) <= MAX_HOLD) begin : g_bad_param
        $error("rr_arbiter4: MAX_HOLD must be 2..15 and fit in CNT_W bits");
    end

    state_t     r_state;
    logic [1:0] r_last;
    logic [1:0] r_idx;
    logic       r_valid;

    state_t     w_nxt_state;
    logic [1:0] w_nxt_last;
    logic [1:0] w_nxt_idx;
    logic       w_nxt_valid;
    logic [3:0] w_gnt;
    logic [3:0] w_others;
    logic       w_rotate;
    pick_t      w_pick;

    // In IDLE w_gnt is zero, so w_others is the full request vector.
    assign w_others = bus.req & ~w_gnt;
    assign w_pick   = rr_pick(w_others, (r_state == ST_GRANT) ? r_idx : r_last);

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;

    assign w_rotate = !bus.req[r_idx]
                    || ((r_cnt == CNT_W'(MAX_HOLD - 1)) && (|w_others));
`else
    assign w_rotate = !bus.req[r_idx];
`endif

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_last  = r_last;
        w_nxt_idx   = r_idx;
        w_nxt_valid = r_valid;
`ifdef ARB_TIMEOUT_EN
        w_nxt_cnt   = r_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick.found) begin
                    w_nxt_state = ST_GRANT;
                    w_nxt_idx   = w_pick.idx;
                    w_nxt_valid = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_nxt_cnt   = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (w_rotate) begin
                    w_nxt_last = r_idx;
                    if (w_pick.found) begin
                        w_nxt_idx = w_pick.idx;
                    end else begin
                        w_nxt_state = ST_IDLE;
                        w_nxt_valid = 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    w_nxt_cnt = '0;
                end else if (r_cnt != CNT_W'(MAX_HOLD)) begin
                    w_nxt_cnt = r_cnt + 1'b1;
`endif
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 2'd3;
            r_idx   <= 2'd0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_last  <= w_nxt_last;
            r_idx   <= w_nxt_idx;
            r_valid <= w_nxt_valid;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_cnt <= '0;
        else     r_cnt <= w_nxt_cnt;
    end
`endif

    arb_dec2to4 u_dec (
        .i_idx    (r_idx),
        .i_en     (r_valid),
        .o_onehot (w_gnt)
    );

    assign bus.gnt       = w_gnt;
    assign bus.gnt_idx   = r_idx;
    assign bus.gnt_valid = r_valid;
    assign bus.busy      = (r_state == ST_GRANT);

endmodule
